// File: rtl/i2s_rx_master.sv
// I2S master receiver: SCK/WS generation, MSB-first capture of SD,
// one right-justified word per enabled channel on a valid/ready stream.
`timescale 1ns/1ps
module i2s_rx_master #(
  parameter int DW      = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] sck_prescaler,
  input  logic [5:0]         sample_size,
  input  logic               ws_dly,
  input  logic               sign_ext,
  input  logic [1:0]         chan_en,
  input  logic               sd,
  output logic               sck,
  output logic               ws,
  output logic [DW-1:0]      sample_data,
  output logic               sample_chan,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int SW = $clog2(DW + 64) + 1;

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               sck_q, sck_d;
  logic               ws_q, ws_d;
  logic [CW-1:0]      bcnt_q, bcnt_d;
  logic [DW-1:0]      shreg_q, shreg_d;
  logic [DW-1:0]      data_q, data_d;
  logic               chan_q, chan_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic          wrap, fall, last_bit;
  logic [SW-1:0] size_req, size_lim, size_eff;
  logic [SW-1:0] k, j;
  logic          in_win, first, done, take;
  logic [DW-1:0] word, mask, top, ext;
  logic          sign;

  assign wrap     = (pcnt_q == sck_prescaler);
  assign fall     = en && wrap && sck_q;
  assign last_bit = (bcnt_q == CW'(DW - 1));

  // Slot position k maps to word bit j; only j in [0, S) is captured.
  always_comb begin
    size_req = (sample_size == '0) ? SW'(1) : SW'(sample_size);
    size_lim = SW'(DW) - SW'(ws_dly);
    size_eff = (size_req < size_lim) ? size_req : size_lim;
    k        = SW'(bcnt_q);
    j        = k - SW'(ws_dly);
    in_win   = (k >= SW'(ws_dly)) && (j < size_eff);
    first    = in_win && (j == '0);
    done     = in_win && (j == size_eff - SW'(1));
    take     = fall && in_win && chan_en[ws_q];
  end

  always_comb begin
    word = first ? DW'(sd) : {shreg_q[DW-2:0], sd};
    for (int i = 0; i < DW; i++) begin
      mask[i] = (SW'(i) < size_eff);
    end
    top  = mask & ~(mask >> 1);
    sign = |(word & top);
    ext  = (word & mask) | ((sign_ext && sign) ? ~mask : '0);
  end

  always_comb begin
    pcnt_d  = pcnt_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;

    if (!en) begin
      pcnt_d  = '0;
      sck_d   = 1'b0;
      ws_d    = 1'b0;
      bcnt_d  = '0;
      shreg_d = '0;
    end else begin
      pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
      if (wrap) sck_d = ~sck_q;
      if (fall) begin
        bcnt_d = last_bit ? '0 : bcnt_q + 1'b1;
        if (last_bit) ws_d = ~ws_q;
      end
      if (take) shreg_d = word;
    end

    if (valid_q && sample_ready) valid_d = 1'b0;

    // A held, unaccepted word wins over a newly completed one.
    if (take && done) begin
      if (valid_q && !sample_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = ext;
        chan_d  = ws_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q  <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      chan_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sample_data  = data_q;
  assign sample_chan  = chan_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: bus-level mic model driving sd,
// vector table of configurations, scoreboard queue of expected words.
`timescale 1ns/1ps
module tb_i2s_rx_master;

  localparam int DW = 32;
  localparam int PW = 8;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] presc = '0;
  logic [5:0]    size = 6'd18;
  logic          dly = 1'b0;
  logic          sext = 1'b0;
  logic [1:0]    ce = 2'b11;
  logic          sd = 1'b0;
  logic          ready = 1'b1;
  logic          sck, ws, chan, valid, ovr;
  logic [DW-1:0] data;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        c;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    int          p;
    int          s;
    bit          dl;
    bit          x;
    bit [1:0]    c;
    int          w;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  exp_t q[$];

  int          mic_w = 18;
  logic [31:0] mic_l = 32'h0;
  logic [31:0] mic_r = 32'h0;

  i2s_rx_master #(.DW(DW), .PRESC_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sck_prescaler(presc),
    .sample_size(size),
    .ws_dly(dly),
    .sign_ext(sext),
    .chan_en(ce),
    .sd(sd),
    .sck(sck),
    .ws(ws),
    .sample_data(data),
    .sample_chan(chan),
    .sample_valid(valid),
    .sample_ready(ready),
    .overrun(ovr)
  );

  always #5 clk = ~clk;

  function automatic void check(string n, logic [31:0] act,
                                logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, req);
    end
  endfunction

  // Device: on each SCK rise, shift out the next bit of the word for ws.
  int   mic_cnt = -1;
  logic mic_ws = 1'b0;
  logic mic_ps = 1'b0;
  always @(negedge clk) begin
    int b;
    logic [31:0] w;
    if (!en) begin
      mic_cnt = -1;
      mic_ws  = 1'b0;
    end else if (sck && !mic_ps) begin
      mic_cnt = (ws != mic_ws) ? 0 : mic_cnt + 1;
      mic_ws  = ws;
      b = mic_cnt - int'(dly);
      w = ws ? mic_r : mic_l;
      if (b >= 0 && b < mic_w) sd = w[mic_w-1-b];
      else sd = 1'($urandom);
    end
    mic_ps = sck;
  end

  // Scoreboard pop plus bus-timing checks.
  logic        p_sck = 1'b0, p_ws = 1'b0, p_valid = 1'b0;
  logic        p_ready = 1'b0, p_ovr = 1'b0, p_chan = 1'b0;
  logic [31:0] p_data = '0;
  int          falls = 0, hi = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid && ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h chan %0d want none",
                   data, chan);
        end else begin
          e = q.pop_front();
          check("word_data", data, e.d);
          check("word_chan", 32'(chan), 32'(e.c));
        end
      end
      if (p_valid && !p_ready && valid) begin
        check("held_data", data, p_data);
        check("held_chan", 32'(chan), 32'(p_chan));
      end
      if (ovr) check("ovr_width", 32'(p_ovr), 32'd0);
      if (en) begin
        if (sck) hi++;
        if (p_sck && !sck) begin
          check("sck_high", 32'(hi), 32'(presc) + 32'd1);
          hi = 0;
          falls++;
        end
        if (ws != p_ws) begin
          check("ws_on_fall", 32'(p_sck && !sck), 32'd1);
          check("ws_slot", 32'(falls), 32'(DW));
          falls = 0;
        end
      end else begin
        falls = 0;
        hi = 0;
      end
    end
    p_sck   = sck;
    p_ws    = ws;
    p_valid = valid;
    p_ready = ready;
    p_ovr   = ovr;
    p_data  = data;
    p_chan  = chan;
  end

  function automatic vec_t mk(int p, int s, bit dl, bit x, bit [1:0] c,
                              int w, logic [31:0] l, logic [31:0] r,
                              logic [31:0] el, logic [31:0] er);
    vec_t v;
    v.p = p; v.s = s; v.dl = dl; v.x = x; v.c = c; v.w = w;
    v.l = l; v.r = r; v.el = el; v.er = er;
    return v;
  endfunction

  task automatic set_cfg(vec_t v);
    presc = PW'(v.p);
    size  = 6'(v.s);
    dly   = v.dl;
    sext  = v.x;
    ce    = v.c;
    mic_w = v.w;
    mic_l = v.l;
    mic_r = v.r;
  endtask

  task automatic wait_empty(int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d words pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic go(logic v);
    @(posedge clk);
    #1 en = v;
  endtask

  task automatic idle_check(string n);
    repeat (2) @(posedge clk);
    #1 check(n, 32'({sck, ws}), 32'd0);
  endtask

  localparam logic [31:0] L18 = 32'h0001_0A0B;
  localparam logic [31:0] R18 = 32'h0002_0D0F;
  localparam logic [31:0] L32 = 32'hDEAD_BEEF;
  localparam logic [31:0] R32 = 32'h1234_5678;

  initial begin
    vec_t v[NV];
    int   n;
    int   lim;

    v[0] = mk(1, 18, 0, 0, 2'b11, 18, L18, R18, 32'h00010A0B, 32'h00020D0F);
    v[1] = mk(1, 18, 0, 1, 2'b11, 18, L18, R18, 32'h00010A0B, 32'hFFFE0D0F);
    v[2] = mk(3, 18, 0, 0, 2'b11, 18, L18, R18, 32'h00010A0B, 32'h00020D0F);
    v[3] = mk(1, 18, 0, 0, 2'b01, 18, L18, R18, 32'h00010A0B, 32'h00020D0F);
    v[4] = mk(0, 18, 1, 0, 2'b11, 18, L18, R18, 32'h00010A0B, 32'h00020D0F);
    v[5] = mk(1, 8,  0, 1, 2'b11, 18, L18, R18, 32'h00000042, 32'hFFFFFF83);
    v[6] = mk(1, 0,  0, 1, 2'b11, 18, L18, R18, 32'h00000000, 32'hFFFFFFFF);
    v[7] = mk(2, 32, 0, 0, 2'b10, 32, L32, R32, 32'hDEADBEEF, 32'h12345678);
    v[8] = mk(1, 32, 1, 1, 2'b11, 32, L32, R32, 32'hEF56DF77, 32'h091A2B3C);
    v[9] = mk(1, 63, 0, 0, 2'b11, 32, L32, R32, 32'hDEADBEEF, 32'h12345678);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);

    // First SCK rise lands sck_prescaler+1 cycles after enable.
    set_cfg(v[2]);
    go(1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!sck && n < 50);
    check("first_rise", 32'(n), 32'd4);
    go(1'b0);
    idle_check("idle_first");

    for (int i = 0; i < NV; i++) begin
      set_cfg(v[i]);
      for (int f = 0; f < 2; f++) begin
        if (v[i].c[0]) q.push_back('{c: 1'b0, d: v[i].el});
        if (v[i].c[1]) q.push_back('{c: 1'b1, d: v[i].er});
      end
      lim = 6 * DW * 2 * (v[i].p + 1) + 100;
      go(1'b1);
      wait_empty(lim);
      go(1'b0);
      idle_check("idle_vec");
      repeat (10) @(posedge clk);
    end

    // Stalled consumer: first word held, later completions overrun.
    set_cfg(v[0]);
    @(posedge clk);
    #1 ready = 1'b0;
    q.push_back('{c: 1'b0, d: 32'h00010A0B});
    go(1'b1);
    n = 0;
    for (int c = 0; c < 2000 && n < 3; c++) begin
      @(negedge clk);
      if (ovr) n++;
    end
    check("ovr_count", 32'(n), 32'd3);
    check("ovr_data", data, 32'h00010A0B);
    @(posedge clk);
    #1 ready = 1'b1;
    wait_empty(100);
    go(1'b0);
    idle_check("idle_ovr");
    repeat (10) @(posedge clk);

    // Drop en part-way into the left slot, then restart cleanly.
    set_cfg(v[0]);
    go(1'b1);
    repeat (40) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 check("drop_idle", 32'({sck, ws}), 32'd0);
    repeat (300) @(posedge clk);
    #1 check("drop_novalid", 32'(valid), 32'd0);
    q.push_back('{c: 1'b0, d: 32'h00010A0B});
    q.push_back('{c: 1'b1, d: 32'h00020D0F});
    go(1'b1);
    wait_empty(1000);
    go(1'b0);
    idle_check("idle_drop");
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
